// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester unified memory port arbiter; option macro MEM_ARB_FIXED_PRIO_EN
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
            $error("mem_arbiter: MEM_LAT must be within 1..4");
        end
    endgenerate

    // Index of the final ACCESS cycle of a read.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic       acc_wr;
    logic [1:0] lat_cnt;
    logic       winner;
    logic       any_valid;

    assign any_valid = req0_valid | req1_valid;
    assign busy      = (state != IDLE);

    // Pick the requester that would own the port if it were free this cycle.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant;
`endif
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus handshake outputs; handshakes are masked while reset is held.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        case (state)
            IDLE: begin
                if (reset && any_valid) begin
                    req0_ready = ~winner;
                    req1_ready = winner;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (acc_wr || (lat_cnt == LAT_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                req0_done  = reset & ~gnt_id;
                req1_done  = reset & gnt_id;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory drive registers, grant bookkeeping, latency counter and read capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            rdata      <= '0;
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
            acc_wr     <= 1'b0;
            lat_cnt    <= 2'd0;
        end else begin
            // The write strobe lives for the single cycle after acceptance.
            mem_wr <= 1'b0;
            if (state == IDLE && any_valid) begin
                mem_addr   <= winner ? req1_addr  : req0_addr;
                mem_wdata  <= winner ? req1_wdata : req0_wdata;
                mem_wr     <= winner ? req1_wr    : req0_wr;
                acc_wr     <= winner ? req1_wr    : req0_wr;
                gnt_id     <= winner;
                last_grant <= winner;
                lat_cnt    <= 2'd0;
            end else if (state == ACCESS && !acc_wr) begin
                if (lat_cnt == LAT_LAST) begin
                    rdata <= mem_rdata;
                end else begin
                    lat_cnt <= lat_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed scenarios plus randomized model check)
module tb_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Main instance (MEM_LAT = LAT)
    logic          reset;
    logic          req0_valid, req0_wr, req0_ready, req0_done;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_wr, req1_ready, req1_done;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr, busy, gnt_id;

    // Second instance (MEM_LAT = LAT_B) for the reset-abort scenario
    logic          b_reset;
    logic          b_v0, b_wr0, b_rdy0, b_dn0;
    logic [AW-1:0] b_a0;
    logic [DW-1:0] b_wd0;
    logic          b_v1, b_wr1, b_rdy1, b_dn1;
    logic [AW-1:0] b_a1;
    logic [DW-1:0] b_wd1;
    logic [DW-1:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;
    logic          b_mem_wr, b_busy, b_gnt;

    // External memory: unwritten words return a fixed per-address pattern
    logic [31:0]  wmem [256];
    logic [255:0] wvalid;
    logic         mem_clear;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        init_val = (a == 8'h10) ? 32'hDEADBEEF : {a, ~a, a ^ 8'h5a, 8'hc3};
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            wvalid <= '0;
        end else if (mem_wr) begin
            wmem[mem_addr[7:0]]   <= mem_wdata;
            wvalid[mem_addr[7:0]] <= 1'b1;
        end
    end

    assign mem_rdata   = wvalid[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    assign b_mem_rdata = init_val(b_mem_addr[7:0]);

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(b_reset),
        .req0_valid(b_v0), .req0_wr(b_wr0), .req0_addr(b_a0), .req0_wdata(b_wd0),
        .req0_ready(b_rdy0), .req0_done(b_dn0),
        .req1_valid(b_v1), .req1_wr(b_wr1), .req1_addr(b_a1), .req1_wdata(b_wd1),
        .req1_ready(b_rdy1), .req1_done(b_dn1),
        .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt_id(b_gnt)
    );

    // Reference model: a transaction is a countdown of remaining busy cycles
    int          rem;
    logic        own, lastg, cur_wr;
    logic [31:0] m_addr, m_wdata, m_rdata, pend;
    logic [31:0] ref_mem [256];
    logic        e_rdy0, e_rdy1, e_dn0, e_dn1, e_busy, e_wr;

    task automatic model_reset();
        rem = 0; own = 1'b0; lastg = 1'b1; cur_wr = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; pend = '0;
    endtask

    task automatic model_eval();
        logic win;
        win = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~lastg;
`endif
        end
        e_rdy0 = reset && (rem == 0) && req0_valid && !win;
        e_rdy1 = reset && (rem == 0) && req1_valid && win;
        e_dn0  = reset && (rem == 1) && !own;
        e_dn1  = reset && (rem == 1) && own;
        e_busy = (rem != 0);
        e_wr   = (rem == 2) && cur_wr;
    endtask

    task automatic model_clock();
        if (!reset) begin
            model_reset();
        end else if (e_rdy0 || e_rdy1) begin
            own     = e_rdy1;
            lastg   = e_rdy1;
            cur_wr  = e_rdy1 ? req1_wr : req0_wr;
            m_addr  = e_rdy1 ? req1_addr : req0_addr;
            m_wdata = e_rdy1 ? req1_wdata : req0_wdata;
            rem     = cur_wr ? 2 : LAT + 1;
            if (cur_wr) ref_mem[m_addr[7:0]] = m_wdata;
            else        pend = ref_mem[m_addr[7:0]];
        end else if (rem > 0) begin
            rem--;
            if (rem == 1 && !cur_wr) m_rdata = pend;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h44; req0_wdata = 32'h1;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 32'h48; req1_wdata = 32'h2;
        @(posedge clk); #1 mem_clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
        n_cmp++; if ({req0_done, req1_done} !== 2'b00) begin n_err++; $display("FAIL reset_done got=%b exp=00", {req0_done, req1_done}); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_cmp++; if (gnt_id !== 1'b0) begin n_err++; $display("FAIL reset_gnt_id got=%b exp=0", gnt_id); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL release_ready0 got=%b exp=1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL release_ready1 got=%b exp=0", req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dropped_valid_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_read();
        @(posedge clk); #1 req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h10;
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL read_ready got=%b exp=1", req0_ready); end
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy_access got=%b exp=1", busy); end
            n_cmp++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL read_mem_addr got=%h exp=10", mem_addr); end
            n_cmp++; if (req0_done !== 1'b0) begin n_err++; $display("FAIL read_early_done got=%b exp=0", req0_done); end
            n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL read_mem_wr got=%b exp=0", mem_wr); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (req0_done !== 1'b1) begin n_err++; $display("FAIL read_done got=%b exp=1", req0_done); end
        n_cmp++; if (req1_done !== 1'b0) begin n_err++; $display("FAIL read_done_other got=%b exp=0", req1_done); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rdata got=%h exp=deadbeef", rdata); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy_done got=%b exp=1", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if ({busy, req0_done} !== 2'b00) begin n_err++; $display("FAIL read_after got=%b exp=00", {busy, req0_done}); end
    endtask

    task automatic test_write();
        @(posedge clk); #1 req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h12345678;
        @(negedge clk);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL write_ready got=%b exp=01", {req0_ready, req1_ready}); end
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_wr !== 1'b1) begin n_err++; $display("FAIL write_mem_wr got=%b exp=1", mem_wr); end
        n_cmp++; if (mem_addr !== 32'h20) begin n_err++; $display("FAIL write_mem_addr got=%h exp=20", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL write_mem_wdata got=%h exp=12345678", mem_wdata); end
        n_cmp++; if (gnt_id !== 1'b1) begin n_err++; $display("FAIL write_gnt_id got=%b exp=1", gnt_id); end
        n_cmp++; if (req1_done !== 1'b0) begin n_err++; $display("FAIL write_early_done got=%b exp=0", req1_done); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL write_mem_wr_len got=%b exp=0", mem_wr); end
        n_cmp++; if ({req0_done, req1_done} !== 2'b01) begin n_err++; $display("FAIL write_done got=%b exp=01", {req0_done, req1_done}); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_rdata_hold got=%h exp=deadbeef", rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_after_busy got=%b exp=0", busy); end
    endtask

    task automatic test_contention();
`ifdef MEM_ARB_FIXED_PRIO_EN
        int exp_order[4] = '{0, 0, 0, 1};
`else
        int exp_order[4] = '{0, 1, 0, 1};
`endif
        int   ng = 0;
        int   nd = 0;
        logic owners[$];
        logic o;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 32'h40;
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 32'h44;
        for (int cyc = 0; cyc < 80 && nd < 4; cyc++) begin
            @(negedge clk);
            if (req0_done || req1_done) begin
                o = (owners.size() != 0) ? owners.pop_front() : ~req1_done;
                n_cmp++;
                if ({req0_done, req1_done, gnt_id} !== {~o, o, o}) begin
                    n_err++; $display("FAIL contention_done got=%b exp=%b", {req0_done, req1_done, gnt_id}, {~o, o, o});
                end
                nd++;
            end
            if (req0_ready || req1_ready) begin
                n_cmp++;
                if ({req0_ready, req1_ready} !== {exp_order[ng] == 0, exp_order[ng] == 1}) begin
                    n_err++; $display("FAIL contention_grant%0d got=%b exp_id=%0d", ng, {req0_ready, req1_ready}, exp_order[ng]);
                end
`ifdef MEM_ARB_FIXED_PRIO_EN
                n_cmp++;
                if (req1_ready && req0_valid) begin
                    n_err++; $display("FAIL fixed_prio_req1_ready got=1 exp=0");
                end
`endif
                owners.push_back(req1_ready);
                ng++;
            end
            @(posedge clk); #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            if (ng >= 3) req0_valid = 1'b0;
`endif
            if (ng >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        n_cmp++;
        if (nd != 4) begin n_err++; $display("FAIL contention_timeout got=%0d exp=4 dones", nd); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        @(posedge clk); #1 b_reset = 1'b1; b_v0 = 1'b1; b_wr0 = 1'b0; b_a0 = 32'h30; b_wd0 = 32'h77;
        @(negedge clk);
        n_cmp++; if ({b_rdy0, b_rdy1} !== 2'b10) begin n_err++; $display("FAIL abort_ready got=%b exp=10", {b_rdy0, b_rdy1}); end
        @(posedge clk); #1 b_v0 = 1'b0;
        @(negedge clk);
        n_cmp++; if ({b_busy, b_mem_addr} !== {1'b1, 32'h30}) begin n_err++; $display("FAIL abort_access1 got=%b/%h exp=1/30", b_busy, b_mem_addr); end
        @(posedge clk); #1 b_reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({b_busy, b_dn0} !== 2'b10) begin n_err++; $display("FAIL abort_access2 got=%b exp=10", {b_busy, b_dn0}); end
        @(posedge clk); #1 b_reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({b_busy, b_dn0, b_dn1, b_mem_wr} !== 4'b0000) begin n_err++; $display("FAIL abort_state got=%b exp=0000", {b_busy, b_dn0, b_dn1, b_mem_wr}); end
        n_cmp++; if ({b_mem_addr, b_mem_wdata, b_rdata} !== 96'h0) begin n_err++; $display("FAIL abort_regs got=%h/%h/%h exp=0", b_mem_addr, b_mem_wdata, b_rdata); end
        n_cmp++; if (b_gnt !== 1'b0) begin n_err++; $display("FAIL abort_gnt got=%b exp=0", b_gnt); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (b_dn0 || b_dn1 || b_busy) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_late_activity got=1 exp=0"); end
    endtask

    task automatic test_random();
        logic acc0, acc1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0; mem_clear = 1'b1;
        @(posedge clk); #1 reset = 1'b1; mem_clear = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            model_eval();
            n_cmp++; if (req0_ready !== e_rdy0) begin n_err++; $display("FAIL rnd_ready0 c=%0d got=%b exp=%b", c, req0_ready, e_rdy0); end
            n_cmp++; if (req1_ready !== e_rdy1) begin n_err++; $display("FAIL rnd_ready1 c=%0d got=%b exp=%b", c, req1_ready, e_rdy1); end
            n_cmp++; if (req0_done !== e_dn0) begin n_err++; $display("FAIL rnd_done0 c=%0d got=%b exp=%b", c, req0_done, e_dn0); end
            n_cmp++; if (req1_done !== e_dn1) begin n_err++; $display("FAIL rnd_done1 c=%0d got=%b exp=%b", c, req1_done, e_dn1); end
            n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
            n_cmp++; if (mem_wr !== e_wr) begin n_err++; $display("FAIL rnd_mem_wr c=%0d got=%b exp=%b", c, mem_wr, e_wr); end
            n_cmp++; if (mem_addr !== m_addr) begin n_err++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, m_addr); end
            n_cmp++; if (mem_wdata !== m_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c=%0d got=%h exp=%h", c, mem_wdata, m_wdata); end
            n_cmp++; if (rdata !== m_rdata) begin n_err++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            n_cmp++; if (gnt_id !== own) begin n_err++; $display("FAIL rnd_gnt_id c=%0d got=%b exp=%b", c, gnt_id, own); end
            acc0 = e_rdy0; acc1 = e_rdy1;
            @(posedge clk);
            model_clock();
            #1;
            reset = ($urandom_range(0, 99) != 0);
            if (req0_valid && !acc0) begin
                if ($urandom_range(0, 19) == 0) req0_valid = 1'b0;
            end else begin
                req0_valid = ($urandom_range(0, 9) < 5);
                req0_wr    = 1'($urandom_range(0, 1));
                req0_addr  = {24'h0, 8'($urandom)};
                req0_wdata = $urandom;
            end
            if (req1_valid && !acc1) begin
                if ($urandom_range(0, 19) == 0) req1_valid = 1'b0;
            end else begin
                req1_valid = ($urandom_range(0, 9) < 5);
                req1_wr    = 1'($urandom_range(0, 1));
                req1_addr  = {24'h0, 8'($urandom)};
                req1_wdata = $urandom;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        mem_clear = 1'b1; reset = 1'b0;
        req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
        b_reset = 1'b0;
        b_v0 = 1'b0; b_wr0 = 1'b0; b_a0 = '0; b_wd0 = '0;
        b_v1 = 1'b0; b_wr1 = 1'b0; b_a1 = '0; b_wd1 = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single unified memory (instruction and data in one array) between two requesters.
- Requester 0 is the CPU control path (instruction fetch and load/store through the IorD address path).
- Requester 1 is the program loader / debug port.
- Serialises accesses, drives the memory address/write controls, counts the memory read latency and returns read data with a done pulse, so the control unit stalls cleanly when the port is busy.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  CPU request.
- req0_wr  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  CPU address.
- req0_wdata  in  DATA_W  CPU write data.
- req0_ready  out  1  CPU request accepted this cycle.
- req0_done  out  1  CPU transaction complete (1-cycle pulse).
- req1_valid  in  1  loader request.
- req1_wr  in  1  loader write/read.
- req1_addr  in  ADDR_W  loader address.
- req1_wdata  in  DATA_W  loader write data.
- req1_ready  out  1  loader accepted.
- req1_done  out  1  loader complete pulse.
- rdata  out  DATA_W  read data, valid when reqN_done is high for a read.
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction in flight (state != IDLE).
- gnt_id  out  1  requester owning the current/last transaction.

Behaviour:
- Clock/reset: one clock clk; reset synchronous, active-low.
- Reset values: state=IDLE; all ready/done=0; mem_wr=0; mem_addr=0; mem_wdata=0; rdata=0; busy=0; gnt_id=0; last_grant=1 (so req0 wins the first conflict); latency counter=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - reqN_ready is combinational, asserted only in IDLE, for the arbitration winner whose valid=1.
  - On that edge the arbiter registers addr/wr/wdata into the mem_* drive registers, sets gnt_id=winner, updates last_grant, and moves to ACCESS.
- Arbitration (default): round-robin. One valid wins outright. Both valid: the requester != last_grant wins.
- ACCESS, write: mem_wr=1 for exactly the first ACCESS cycle, then DONE.
- ACCESS, read:
  - Stay MEM_LAT cycles, counter counts 0..MEM_LAT-1.
  - On the final ACCESS cycle, capture mem_rdata into rdata, then DONE.
- DONE:
  - req[gnt_id]_done=1 for one cycle, then IDLE.
  - rdata holds until the next read capture; it is unchanged on writes.
- Latency, accept at edge T:
  - Read: done high in cycle T+MEM_LAT+1.
  - Write: done high in cycle T+2.
  - No new acceptance until IDLE, so minimum spacing is MEM_LAT+2 cycles for reads and 3 for writes.
- mem_addr, mem_wdata: hold their last values outside ACCESS. mem_wr=0 everywhere except the write cycle.
- Requester rules:
  - Requester holds valid/addr/wr/wdata stable until ready.
  - Valid dropped before ready means no transaction and no side effect.
  - Valid held through DONE means the next request is arbitrated in the following IDLE cycle.
- Loser of a conflict keeps waiting. Round-robin guarantees it wins the next arbitration.
- Reset mid-transaction (reset=0 in ACCESS/DONE): next edge returns to reset values; no done pulse; an aborted write stops at that edge.
- Illegal MEM_LAT outside 1..4: elaboration-time error.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins a conflict and last_grant is ignored; req1 can starve.
- Undefined: round-robin as described above.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both valid=1 -> ready/done/mem_wr/busy all 0, mem_addr=0; release -> req0_ready=1 in the first IDLE cycle.
- Single read, MEM_LAT=1: req0 read addr 0x10, mem_rdata=0xDEADBEEF -> mem_addr=0x10 in T+1, req0_done=1 with rdata=0xDEADBEEF in T+2, busy high T+1..T+2.
- Write: req1 write addr 0x20, data 0x12345678 -> mem_wr=1 exactly one cycle with mem_addr=0x20 and mem_wdata=0x12345678, req1_done at T+2, rdata unchanged.
- Contention, round-robin, both valid continuously for 4 transactions -> grant order 0,1,0,1; gnt_id matches; each done goes only to its owner.
- Reset mid-read, MEM_LAT=3: assert reset=0 in the 2nd ACCESS cycle -> no done pulse, state IDLE, busy=0 after the edge.
- MEM_ARB_FIXED_PRIO_EN defined, both valid for 3 transactions -> grants 0,0,0 and req1_ready never asserted; drop req0 -> req1 granted next IDLE.
